// File: rtl/bridge_pkg.sv
// Shared bridge definitions: scheduler state encoding, response status codes,
// frame delimiters and the latched response header layout.
package bridge_pkg;

  localparam int STATUS_W = 8;
  localparam int CMD_W    = 8;
  localparam int ADDR_W   = 32;
  localparam int COUNT_W  = 6;
  localparam int FRAMES_W = 16;

  localparam logic [7:0] SOF_REQ = 8'hA5;
  localparam logic [7:0] SOF_RSP = 8'h5A;

  localparam logic [STATUS_W-1:0] STATUS_OK      = 8'h00;
  localparam logic [STATUS_W-1:0] STATUS_BAD_CMD = 8'h01;
  localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = 8'h02;
  localparam logic [STATUS_W-1:0] STATUS_BUS_ERR = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LAUNCH,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_GAP
  } sched_state_t;

  typedef struct packed {
    logic [STATUS_W-1:0] status;
    logic [CMD_W-1:0]    cmd;
    logic [ADDR_W-1:0]   addr;
    logic [COUNT_W-1:0]  count;
    logic                is_read;
  } rsp_hdr_t;

endpackage

// File: rtl/response_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Tie i_ptr to zero for plain lowest-index-wins priority.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int unsigned w_pos;
  logic        w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = (int'(i_ptr) + k) % N_REQ;
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = IW'(w_pos);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/response_scheduler.sv
// Grants one response source at a time to the frame builder, launches one frame
// per grant and acks the source. Optional RSP_SCHED_WDOG_EN adds a WAIT_DONE watchdog.
module response_scheduler
  import bridge_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FIXED_PRIO = 0,
  parameter int START_TMO  = 8,
  parameter int DONE_TMO   = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*STATUS_W-1:0] req_status,
  input  logic [N_REQ*CMD_W-1:0]    req_cmd,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*COUNT_W-1:0]  req_count,
  input  logic [N_REQ-1:0]          req_is_read,
  output logic [N_REQ-1:0]          rsp_ack,
  output logic                      rsp_abort,
  output logic [N_REQ-1:0]          rsp_sel,
  output logic [STATUS_W-1:0]       fb_status,
  output logic [CMD_W-1:0]          fb_cmd,
  output logic [ADDR_W-1:0]         fb_addr,
  output logic [COUNT_W-1:0]        fb_count,
  output logic                      fb_is_read,
  output logic                      fb_build,
  input  logic                      fb_busy,
  input  logic                      fb_complete,
  output logic [FRAMES_W-1:0]       frames_sent,
  output logic                      sched_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef RSP_SCHED_WDOG_EN
  localparam int TMR_MAX = (DONE_TMO > START_TMO) ? DONE_TMO : START_TMO;
`else
  localparam int TMR_MAX = START_TMO;
`endif
  localparam int TW = $clog2(TMR_MAX + 1);

  sched_state_t r_state, w_nxt;

  logic [N_REQ-1:0]               r_sel;
  logic [IW-1:0]                  r_idx;
  logic [IW-1:0]                  r_ptr;
  rsp_hdr_t                       r_hdr;
  logic                           r_abort;
  logic                           r_err;
  logic [FRAMES_W-1:0]            r_frames;
  logic [TW-1:0]                  r_tmr;

  logic [N_REQ-1:0][STATUS_W-1:0] w_status;
  logic [N_REQ-1:0][CMD_W-1:0]    w_cmd;
  logic [N_REQ-1:0][ADDR_W-1:0]   w_addr;
  logic [N_REQ-1:0][COUNT_W-1:0]  w_count;
  logic [N_REQ-1:0]               w_gnt;
  logic [IW-1:0]                  w_gnt_idx;
  logic [IW-1:0]                  w_ptr;
  logic                           w_any;
  logic                           w_latch;
  logic                           w_tmo;
  logic                           w_tmr_run;

  assign w_status = req_status;
  assign w_cmd    = req_cmd;
  assign w_addr   = req_addr;
  assign w_count  = req_count;
  assign w_ptr    = (FIXED_PRIO != 0) ? '0 : r_ptr;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .i_req (req_valid),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // fb_complete wins over busy/timeout: a very fast builder may finish inside WAIT_START.
  always_comb begin
    w_nxt     = r_state;
    w_latch   = 1'b0;
    w_tmo     = 1'b0;
    w_tmr_run = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_latch = 1'b1;
          w_nxt   = ST_GRANT;
        end
      end
      ST_GRANT:  w_nxt = ST_LAUNCH;
      ST_LAUNCH: w_nxt = ST_WAIT_START;
      ST_WAIT_START: begin
        w_tmr_run = 1'b1;
        if (fb_complete)                        w_nxt = ST_RELEASE;
        else if (fb_busy)                       w_nxt = ST_WAIT_DONE;
        else if (r_tmr == TW'(START_TMO - 1)) begin
          w_tmo = 1'b1;
          w_nxt = ST_RELEASE;
        end
      end
      ST_WAIT_DONE: begin
`ifdef RSP_SCHED_WDOG_EN
        w_tmr_run = 1'b1;
        if (fb_complete)                        w_nxt = ST_RELEASE;
        else if (r_tmr == TW'(DONE_TMO - 1)) begin
          w_tmo = 1'b1;
          w_nxt = ST_RELEASE;
        end
`else
        if (fb_complete) w_nxt = ST_RELEASE;
`endif
      end
      ST_RELEASE: w_nxt = ST_GAP;
      ST_GAP:     w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  // One timer serves both waits; it restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n || (w_nxt != r_state)) r_tmr <= '0;
    else if (w_tmr_run)               r_tmr <= r_tmr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel    <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_hdr    <= '0;
      r_abort  <= 1'b0;
      r_err    <= 1'b0;
      r_frames <= '0;
    end else begin
      if (w_latch) begin
        r_sel         <= w_gnt;
        r_idx         <= w_gnt_idx;
        r_hdr.status  <= w_status[w_gnt_idx];
        r_hdr.cmd     <= w_cmd[w_gnt_idx];
        r_hdr.addr    <= w_addr[w_gnt_idx];
        r_hdr.count   <= w_count[w_gnt_idx];
        r_hdr.is_read <= req_is_read[w_gnt_idx];
        r_abort       <= 1'b0;
      end
      if (w_tmo) begin
        r_abort <= 1'b1;
        r_err   <= 1'b1;
      end
      if (r_state == ST_RELEASE) begin
        if (!r_abort) r_frames <= r_frames + 1'b1;
        r_ptr   <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
        r_sel   <= '0;
        r_hdr   <= '0;
        r_abort <= 1'b0;
      end
    end
  end

  assign rsp_ack     = (r_state == ST_RELEASE) ? r_sel : '0;
  assign rsp_abort   = (r_state == ST_RELEASE) && r_abort;
  assign rsp_sel     = r_sel;
  assign fb_status   = r_hdr.status;
  assign fb_cmd      = r_hdr.cmd;
  assign fb_addr     = r_hdr.addr;
  assign fb_count    = r_hdr.count;
  assign fb_is_read  = r_hdr.is_read;
  assign fb_build    = (r_state == ST_LAUNCH);
  assign frames_sent = r_frames;
  assign sched_err   = r_err;

endmodule

// File: tb/tb_response_scheduler.sv
// Directed bench: a round-robin instance and a fixed-priority instance share clock,
// reset and header inputs; expected values are hand-computed per scenario.
module tb_response_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, fp_req_valid;
  logic [N*8-1:0] req_status, req_cmd;
  logic [N*32-1:0] req_addr;
  logic [N*6-1:0] req_count;
  logic [N-1:0]   req_is_read;
  logic           fb_busy, fb_complete, fp_busy, fp_complete;

  logic [N-1:0]   rsp_ack, rsp_sel, fp_ack, fp_sel;
  logic           rsp_abort, fp_abort;
  logic [7:0]     fb_status, fb_cmd, fp_status, fp_cmd;
  logic [31:0]    fb_addr, fp_addr;
  logic [5:0]     fb_count, fp_count;
  logic           fb_is_read, fb_build, fp_is_read, fp_build;
  logic [15:0]    frames_sent, fp_frames;
  logic           sched_err, fp_err;

  always #5 clk = ~clk;

  response_scheduler #(.N_REQ(N), .FIXED_PRIO(0), .START_TMO(8), .DONE_TMO(4096)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_status(req_status),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_count(req_count), .req_is_read(req_is_read),
    .rsp_ack(rsp_ack), .rsp_abort(rsp_abort), .rsp_sel(rsp_sel), .fb_status(fb_status),
    .fb_cmd(fb_cmd), .fb_addr(fb_addr), .fb_count(fb_count), .fb_is_read(fb_is_read),
    .fb_build(fb_build), .fb_busy(fb_busy), .fb_complete(fb_complete),
    .frames_sent(frames_sent), .sched_err(sched_err)
  );

  response_scheduler #(.N_REQ(N), .FIXED_PRIO(1), .START_TMO(8), .DONE_TMO(4096)) u_dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(fp_req_valid), .req_status(req_status),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_count(req_count), .req_is_read(req_is_read),
    .rsp_ack(fp_ack), .rsp_abort(fp_abort), .rsp_sel(fp_sel), .fb_status(fp_status),
    .fb_cmd(fp_cmd), .fb_addr(fp_addr), .fb_count(fp_count), .fb_is_read(fp_is_read),
    .fb_build(fp_build), .fb_busy(fp_busy), .fb_complete(fp_complete),
    .frames_sent(fp_frames), .sched_err(fp_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Call at a negedge; returns at the LAUNCH negedge with the grant and cycles waited.
  task automatic wait_build(input bit fp, output logic [N-1:0] sel, output int t);
    t = 0;
    while (!(fp ? fp_build : fb_build) && t < 40) begin
      tick();
      t++;
    end
    chk("build_seen", fp ? fp_build : fb_build, 1'b1);
    sel = fp ? fp_sel : rsp_sel;
  endtask

  task automatic wait_ack(input bit fp, input int max_c, output logic [N-1:0] ack,
                          output logic ab, output int t);
    t = 0;
    while ((fp ? fp_ack : rsp_ack) == '0 && t < max_c) begin
      tick();
      t++;
    end
    ack = fp ? fp_ack : rsp_ack;
    ab  = fp ? fp_abort : rsp_abort;
  endtask

  // From the LAUNCH negedge: busy one cycle, then complete; returns at RELEASE negedge.
  task automatic finish_frame(input bit fp, output logic [N-1:0] ack, output logic ab);
    int t;
    tick();
    chk("build_1cyc", fp ? fp_build : fb_build, 1'b0);
    if (fp) fp_busy = 1'b1; else fb_busy = 1'b1;
    tick();
    if (fp) begin fp_busy = 1'b0; fp_complete = 1'b1; end
    else    begin fb_busy = 1'b0; fb_complete = 1'b1; end
    tick();
    if (fp) fp_complete = 1'b0; else fb_complete = 1'b0;
    wait_ack(fp, 5, ack, ab, t);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] sel, ack, exp_sel;
    logic         ab;
    int           t, seen;
    int           exp_frames;

    rst_n        = 1'b0;
    req_valid    = '0;
    fp_req_valid = '0;
    fb_busy      = 1'b0;
    fb_complete  = 1'b0;
    fp_busy      = 1'b0;
    fp_complete  = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_status[i*8 +: 8]  = 8'h10 + 8'(i);
      req_cmd[i*8 +: 8]     = 8'hA0 + 8'(i);
      req_addr[i*32 +: 32]  = 32'h2000_0000 + 32'(i * 16);
      req_count[i*6 +: 6]   = 6'(i + 1);
      req_is_read[i]        = 1'b0;
    end
    req_status[8 +: 8]  = 8'h00;
    req_cmd[8 +: 8]     = 8'hA1;
    req_addr[32 +: 32]  = 32'h1000_0040;
    req_count[6 +: 6]   = 6'd4;
    req_is_read[1]      = 1'b1;

    repeat (3) tick();
    chk("rst_sel",    rsp_sel, 4'b0000);
    chk("rst_ack",    rsp_ack, 4'b0000);
    chk("rst_abort",  rsp_abort, 1'b0);
    chk("rst_build",  fb_build, 1'b0);
    chk("rst_addr",   fb_addr, 32'h0);
    chk("rst_frames", frames_sent, 16'h0);
    chk("rst_err",    sched_err, 1'b0);
    rst_n = 1'b1;

    // Single request from source 1
    req_valid = 4'b0010;
    tick();
    chk("t1_sel",    rsp_sel, 4'b0010);
    chk("t1_build0", fb_build, 1'b0);
    chk("t1_status", fb_status, 8'h00);
    chk("t1_cmd",    fb_cmd, 8'hA1);
    chk("t1_addr",   fb_addr, 32'h1000_0040);
    chk("t1_count",  fb_count, 6'd4);
    chk("t1_isrd",   fb_is_read, 1'b1);
    req_addr[32 +: 32] = 32'hDEAD_BEEF;
    tick();
    chk("t1_lat",      fb_build, 1'b1);
    chk("t1_addr_hold", fb_addr, 32'h1000_0040);
    finish_frame(0, ack, ab);
    chk("t1_ack",   ack, 4'b0010);
    chk("t1_abort", ab, 1'b0);
    req_valid = '0;
    req_addr[32 +: 32] = 32'h1000_0040;
    tick();
    chk("t1_frames", frames_sent, 16'd1);
    chk("t1_selclr", rsp_sel, 4'b0000);
    chk("t1_hdrclr", fb_addr, 32'h0);

    // Round-robin with all four held
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_build(0, sel, t);
      exp_sel = 4'b0001 << (k % 4);
      chk("t2_sel", sel, exp_sel);
      if (k > 0) chk("t2_gap", t, 4);
      finish_frame(0, ack, ab);
      chk("t2_ack", ack, exp_sel);
      chk("t2_abort", ab, 1'b0);
    end
    req_valid = '0;
    tick();
    chk("t2_frames", frames_sent, 16'd5);

    // Start timeout on source 2 (pointer now 1)
    req_valid = 4'b0100;
    wait_build(0, sel, t);
    chk("t4_sel", sel, 4'b0100);
    wait_ack(0, 30, ack, ab, t);
    chk("t4_cycles", t, 9);
    chk("t4_ack",    ack, 4'b0100);
    chk("t4_abort",  ab, 1'b1);
    chk("t4_err",    sched_err, 1'b1);
    req_valid = '0;
    tick();
    chk("t4_frames", frames_sent, 16'd5);
    req_valid = 4'b1000;
    wait_build(0, sel, t);
    chk("t4_next_sel", sel, 4'b1000);
    finish_frame(0, ack, ab);
    chk("t4_next_ack",   ack, 4'b1000);
    chk("t4_next_abort", ab, 1'b0);
    chk("t4_err_sticky", sched_err, 1'b1);
    req_valid = '0;
    tick();
    chk("t4_next_frames", frames_sent, 16'd6);
    exp_frames = 6;

    // Stalled builder in WAIT_DONE (pointer now 0)
    req_valid = 4'b0001;
    wait_build(0, sel, t);
    fb_busy = 1'b1;
`ifdef RSP_SCHED_WDOG_EN
    wait_ack(0, 5000, ack, ab, t);
    chk("t5_cycles", t, 4098);
    chk("t5_ack",    ack, 4'b0001);
    chk("t5_abort",  ab, 1'b1);
    chk("t5_err",    sched_err, 1'b1);
    fb_busy = 1'b0;
`else
    seen = 0;
    repeat (300) begin
      tick();
      if (rsp_ack != '0) seen++;
    end
    chk("t5_no_wdog", seen, 0);
    fb_busy     = 1'b0;
    fb_complete = 1'b1;
    tick();
    fb_complete = 1'b0;
    wait_ack(0, 5, ack, ab, t);
    chk("t5_ack",   ack, 4'b0001);
    chk("t5_abort", ab, 1'b0);
    exp_frames++;
`endif
    req_valid = '0;
    tick();
    chk("t5_frames", frames_sent, 16'(exp_frames));

    // Reset while waiting for completion
    req_valid = 4'b0010;
    wait_build(0, sel, t);
    fb_busy = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("t6_sel",    rsp_sel, 4'b0000);
    chk("t6_ack",    rsp_ack, 4'b0000);
    chk("t6_build",  fb_build, 1'b0);
    chk("t6_cmd",    fb_cmd, 8'h00);
    chk("t6_frames", frames_sent, 16'h0);
    chk("t6_err",    sched_err, 1'b0);
    rst_n     = 1'b1;
    fb_busy   = 1'b0;
    req_valid = '0;
    seen = 0;
    repeat (5) begin
      tick();
      if (rsp_ack != '0) seen++;
    end
    chk("t6_no_ack", seen, 0);

    // frames_sent wrap
    force u_dut.r_frames = 16'hFFFF;
    #1;
    release u_dut.r_frames;
    tick();
    chk("t6_preset", frames_sent, 16'hFFFF);
    req_valid = 4'b0010;
    wait_build(0, sel, t);
    finish_frame(0, ack, ab);
    chk("t6_wrap_ack", ack, 4'b0010);
    req_valid = '0;
    tick();
    chk("t6_wrap", frames_sent, 16'h0000);

    // Fixed priority: source 0 keeps coming back, source 3 starves until it stops
    fp_req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_build(1, sel, t);
      exp_sel = (k < 3) ? 4'b0001 : 4'b1000;
      chk("t3_sel", sel, exp_sel);
      finish_frame(1, ack, ab);
      chk("t3_ack", ack, exp_sel);
      fp_req_valid = (k < 3) ? 4'b1000 : 4'b0000;
      tick();
      if (k < 2) fp_req_valid = 4'b1001;
    end
    chk("t3_frames", fp_frames, 16'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
